dram_line_cache: RTL and testbench
==================================

DRAM_LINE_CACHE -- requirements
Module: dram_line_cache

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  client request strobe
- req_ready  out  1  block can accept a request or flush
- req_wr  in  1  1=write, 0=read
- req_addr  in  8  entry index
- req_wdata  in  64  write data
- flush_valid  in  1  write back dirty line, then invalidate
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  64  response data
- flush_done  out  1  one-cycle flush-complete pulse
- C_in_valid  out  1  one-cycle request pulse to the bridge
- C_r_wb  out  1  1=DRAM read, 0=DRAM write
- C_addr  out  8  DRAM entry index
- C_data_w  out  64  DRAM write data
- C_out_valid  in  1  bridge completion pulse
- C_data_r  in  64  bridge read data, valid with C_out_valid
REQ-002 The block SHALL use one clock (clk) and an asynchronous active-low reset (rst_n).

Function
REQ-003 Storage SHALL be one line: tag[7:0], data[63:0], valid bit, dirty bit.
REQ-004 FSM states SHALL be IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP, FLUSH_DONE.
REQ-005 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid & req_ready, with req_wr, req_addr and req_wdata captured in that cycle.
REQ-006 If flush_valid and req_valid are both high in IDLE, flush SHALL win and the request SHALL not be accepted.
REQ-007 A hit means valid=1 and tag==req_addr.
- Read hit: go to RESP.
- Write hit: data<=req_wdata, dirty<=1, go to RESP.
- Hit latency: resp_valid in the cycle after acceptance.
REQ-008 On a miss with valid & dirty, the block SHALL go to WB_REQ.
- In WB_REQ: C_in_valid=1 for exactly one cycle, C_r_wb=0, C_addr=tag, C_data_w=line data.
- In WB_WAIT: wait for C_out_valid, then clear dirty and continue as a clean miss.
REQ-009 On a clean read miss, the block SHALL go to FILL_REQ.
- In FILL_REQ: C_in_valid=1 for one cycle, C_r_wb=1, C_addr=captured addr.
- In FILL_WAIT: on C_out_valid, load data<=C_data_r, tag<=addr, valid<=1, dirty<=0, go to RESP.
REQ-010 A clean write miss SHALL perform no DRAM read.
- Install tag<=addr, data<=wdata, valid<=1, dirty<=1.
- Go to RESP.
REQ-011 RESP SHALL assert resp_valid for exactly one cycle with resp_rdata = line data after update, then return to IDLE.
REQ-012 Flush behaviour:
- Dirty line: perform the write-back of REQ-008, then clear valid.
- Clean or invalid line: clear valid with no DRAM access.
- Then assert flush_done for one cycle in FLUSH_DONE and return to IDLE.
REQ-013 C_r_wb, C_addr and C_data_w SHALL be registered and held stable from the C_in_valid cycle through the C_out_valid cycle.
REQ-014 The block SHALL ignore C_data_r on write-back completion.
REQ-015 The block SHALL ignore C_out_valid in any state other than WB_WAIT and FILL_WAIT.
REQ-016 At most one bridge transaction SHALL be outstanding; C_in_valid SHALL never assert in WB_WAIT or FILL_WAIT.
REQ-017 DRAM wait time SHALL be unbounded; the block stays in WB_WAIT/FILL_WAIT until C_out_valid.

Reset
REQ-018 rst_n low SHALL immediately force state to IDLE and clear valid, dirty, tag, data and all registered outputs to 0; req_ready SHALL be 1 after reset.
REQ-019 Reset during WB_WAIT or FILL_WAIT SHALL abandon the transaction and discard the pending response.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Read 0x10 after reset -> C_in_valid one cycle later with C_r_wb=1, C_addr=0x10; bridge returns 0x1122334455667788 -> resp_valid next cycle with that data.
- Read 0x10 again -> resp_valid at acceptance+1 with the same data and no C_in_valid.
- Write 0x10 with 0xAAAA -> resp_valid at +1 with rdata=0xAAAA; then read 0x20 -> write-back (C_r_wb=0, C_addr=0x10, C_data_w=0xAAAA), then fill of 0x20, then response.
- Write miss 0x30 on a clean line -> no C_in_valid; resp at +1; then flush -> write-back of 0x30, then flush_done; next read 0x30 misses.
- flush_valid and req_valid in the same cycle -> flush performed, request stays pending and is accepted once req_ready returns.
- rst_n pulsed low in FILL_WAIT -> all outputs 0 immediately, no resp_valid; a later C_out_valid is ignored.

Source files
------------

// File: rtl/dram_line_cache_if.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache_if
// Description : Client request/response bus plus DRAM bridge request bus for
//               the single-line DRAM cache. The slave modport is the cache.
// Revision    : 1.0 - initial release
// ============================================================================
interface dram_line_cache_if;
  // client side
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        flush_valid;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        flush_done;
  // bridge side
  logic        C_in_valid;
  logic        C_r_wb;
  logic [7:0]  C_addr;
  logic [63:0] C_data_w;
  logic        C_out_valid;
  logic [63:0] C_data_r;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, flush_valid,
    input  C_out_valid, C_data_r,
    output req_ready, resp_valid, resp_rdata, flush_done,
    output C_in_valid, C_r_wb, C_addr, C_data_w
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, flush_valid,
    output C_out_valid, C_data_r,
    input  req_ready, resp_valid, resp_rdata, flush_done,
    input  C_in_valid, C_r_wb, C_addr, C_data_w
  );
endinterface
`default_nettype wire

// File: rtl/dram_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : dram_line_cache
// Description : One-line write-back cache in front of a DRAM bridge. Hits
//               respond the cycle after acceptance; misses write back a dirty
//               line and/or fill from DRAM. Flush writes back and invalidates.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_line_cache (
  input  wire logic         clk,
  input  wire logic         rst_n,
  dram_line_cache_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WB_REQ     = 3'd1,
    WB_WAIT    = 3'd2,
    FILL_REQ   = 3'd3,
    FILL_WAIT  = 3'd4,
    RESP       = 3'd5,
    FLUSH_DONE = 3'd6
  } state_t;

  state_t      r_state;
  // the cached line
  logic [7:0]  r_tag;
  logic [63:0] r_data;
  logic        r_valid;
  logic        r_dirty;
  // captured operation
  logic        r_flush;
  logic        r_wr;
  logic [7:0]  r_addr;
  logic [63:0] r_wdata;
  // registered outputs
  logic        r_resp_valid;
  logic [63:0] r_resp_rdata;
  logic        r_flush_done;
  logic        r_c_in_valid;
  logic        r_c_r_wb;
  logic [7:0]  r_c_addr;
  logic [63:0] r_c_data_w;

  logic        w_hit;

  assign w_hit          = r_valid && (r_tag == bus.req_addr);

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.flush_done = r_flush_done;
  assign bus.C_in_valid = r_c_in_valid;
  assign bus.C_r_wb     = r_c_r_wb;
  assign bus.C_addr     = r_c_addr;
  assign bus.C_data_w   = r_c_data_w;

  // Control FSM, line storage and all registered outputs. Pulse outputs
  // default low each cycle; bridge address/data hold until the next request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tag        <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_dirty      <= 1'b0;
      r_flush      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_flush_done <= 1'b0;
      r_c_in_valid <= 1'b0;
      r_c_r_wb     <= 1'b0;
      r_c_addr     <= '0;
      r_c_data_w   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_flush_done <= 1'b0;
      r_c_in_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // flush takes priority over a simultaneous request
          if (bus.flush_valid) begin
            r_flush <= 1'b1;
            if (r_valid && r_dirty) begin
              r_c_in_valid <= 1'b1;
              r_c_r_wb     <= 1'b0;
              r_c_addr     <= r_tag;
              r_c_data_w   <= r_data;
              r_state      <= WB_REQ;
            end else begin
              r_valid      <= 1'b0;
              r_flush_done <= 1'b1;
              r_state      <= FLUSH_DONE;
            end
          end else if (bus.req_valid) begin
            r_flush <= 1'b0;
            r_wr    <= bus.req_wr;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            if (w_hit) begin
              if (bus.req_wr) begin
                r_data       <= bus.req_wdata;
                r_dirty      <= 1'b1;
                r_resp_rdata <= bus.req_wdata;
              end else begin
                r_resp_rdata <= r_data;
              end
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else if (r_valid && r_dirty) begin
              r_c_in_valid <= 1'b1;
              r_c_r_wb     <= 1'b0;
              r_c_addr     <= r_tag;
              r_c_data_w   <= r_data;
              r_state      <= WB_REQ;
            end else if (bus.req_wr) begin
              // clean write miss installs directly, no DRAM read needed
              r_tag        <= bus.req_addr;
              r_data       <= bus.req_wdata;
              r_valid      <= 1'b1;
              r_dirty      <= 1'b1;
              r_resp_rdata <= bus.req_wdata;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_c_in_valid <= 1'b1;
              r_c_r_wb     <= 1'b1;
              r_c_addr     <= bus.req_addr;
              r_state      <= FILL_REQ;
            end
          end
        end
        WB_REQ: r_state <= WB_WAIT;
        WB_WAIT: begin
          // write-back completion: read data from the bridge is irrelevant
          if (bus.C_out_valid) begin
            r_dirty <= 1'b0;
            if (r_flush) begin
              r_valid      <= 1'b0;
              r_flush_done <= 1'b1;
              r_state      <= FLUSH_DONE;
            end else if (r_wr) begin
              r_tag        <= r_addr;
              r_data       <= r_wdata;
              r_valid      <= 1'b1;
              r_dirty      <= 1'b1;
              r_resp_rdata <= r_wdata;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end else begin
              r_c_in_valid <= 1'b1;
              r_c_r_wb     <= 1'b1;
              r_c_addr     <= r_addr;
              r_state      <= FILL_REQ;
            end
          end
        end
        FILL_REQ: r_state <= FILL_WAIT;
        FILL_WAIT: begin
          if (bus.C_out_valid) begin
            r_data       <= bus.C_data_r;
            r_tag        <= r_addr;
            r_valid      <= 1'b1;
            r_dirty      <= 1'b0;
            r_resp_rdata <= bus.C_data_r;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP:       r_state <= IDLE;
        FLUSH_DONE: r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_line_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_line_cache
// Description : Self-checking bench for dram_line_cache: directed scenarios
//               plus randomized traffic against a line/memory reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_line_cache;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_line_cache_if bus ();

  dram_line_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // DRAM contents seen by the bridge, and the architectural memory image
  logic [63:0] mem  [256];
  logic [63:0] arch [256];
  // model of which address the line holds and whether it differs from DRAM
  bit          mv, md;
  logic [7:0]  mt;
  logic [63:0] mdat;

  // shared result variables (tests run strictly one after another)
  int          rc, dc, fc, nwb, nf, ewb, efill, d;
  logic [7:0]  wa, fa, ewa;
  logic [63:0] rd, wdd, ewd, erd;
  bit          ok;

  task automatic model_reset();
    mv = 1'b0; md = 1'b0; mt = '0; mdat = '0;
    for (int i = 0; i < 256; i++) arch[i] = mem[i];
  endtask

  task automatic model_req(input bit wr, input logic [7:0] a, input logic [63:0] wd,
                           output int o_wb, output logic [7:0] o_wa, output logic [63:0] o_wd,
                           output int o_fill, output logic [63:0] o_rd);
    o_wb = 0; o_fill = 0; o_wa = '0; o_wd = '0;
    if (wr) arch[a] = wd;
    if (!(mv && mt == a)) begin
      if (mv && md) begin o_wb = 1; o_wa = mt; o_wd = mdat; end
      o_fill = wr ? 0 : 1;
      mv = 1'b1; mt = a; md = 1'b0;
    end
    if (wr) md = 1'b1;
    mdat = arch[a];
    o_rd = arch[a];
  endtask

  task automatic model_flush(output int o_wb, output logic [7:0] o_wa, output logic [63:0] o_wd);
    o_wb = (mv && md) ? 1 : 0; o_wa = mt; o_wd = mdat;
    mv = 1'b0; md = 1'b0;
  endtask

  // Drives a flush and/or request, acts as the DRAM bridge with a response
  // delay of dl cycles, and reports what was observed (cycles counted from
  // the first acceptance edge, sampled on falling edges).
  task automatic run_op(input bit do_flush, input bit do_req, input bit wr,
                        input logic [7:0] a, input logic [63:0] wd, input int dl,
                        output int resp_cyc, output logic [63:0] rdata, output int done_cyc,
                        output int first_cin, output int n_wb, output int n_fill,
                        output logic [7:0] wb_addr, output logic [63:0] wb_data,
                        output logic [7:0] fill_addr, output bit pok);
    int cyc, cnt;
    bit started, pend, acc_f, acc_r, finished;
    logic        hr;
    logic [7:0]  ha;
    logic [63:0] hd;
    resp_cyc = -1; done_cyc = -1; first_cin = -1; n_wb = 0; n_fill = 0;
    rdata = '0; wb_addr = '0; wb_data = '0; fill_addr = '0; pok = 1'b1;
    cyc = 0; cnt = 0; started = 0; pend = 0; finished = 0;
    hr = 1'b0; ha = '0; hd = '0;
    @(negedge clk);
    bus.flush_valid = do_flush; bus.req_valid = do_req; bus.req_wr = wr;
    bus.req_addr = a; bus.req_wdata = wd;
    for (int it = 0; it < 400 && !finished; it++) begin
      acc_f = bus.req_ready && bus.flush_valid;
      acc_r = bus.req_ready && !bus.flush_valid && bus.req_valid;
      @(negedge clk);
      if (acc_f) bus.flush_valid = 1'b0;
      if (acc_r) bus.req_valid = 1'b0;
      if (acc_f || acc_r) started = 1;
      if (started) cyc++;
      bus.C_out_valid = 1'b0;
      if (pend && (bus.C_r_wb !== hr || bus.C_addr !== ha || bus.C_data_w !== hd)) pok = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          bus.C_out_valid = 1'b1;
          if (hr) bus.C_data_r = mem[ha];
          else begin mem[ha] = hd; bus.C_data_r = {$urandom, $urandom}; end
        end
      end
      if (bus.C_in_valid === 1'b1) begin
        if (pend) pok = 1'b0;
        if (first_cin < 0) first_cin = cyc;
        hr = bus.C_r_wb; ha = bus.C_addr; hd = bus.C_data_w;
        pend = 1; cnt = dl;
        if (hr) begin n_fill++; fill_addr = ha; end
        else begin n_wb++; wb_addr = ha; wb_data = hd; end
      end
      if (bus.resp_valid === 1'b1) begin
        if (resp_cyc >= 0) pok = 1'b0;
        resp_cyc = cyc; rdata = bus.resp_rdata;
      end
      if (bus.flush_done === 1'b1) begin
        if (done_cyc >= 0) pok = 1'b0;
        done_cyc = cyc;
      end
      finished = (!do_flush || done_cyc >= 0) && (!do_req || resp_cyc >= 0);
    end
    if (!finished) pok = 1'b0;
    bus.flush_valid = 1'b0; bus.req_valid = 1'b0; bus.C_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    tests_run++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.flush_done !== 1'b0 ||
        bus.C_in_valid !== 1'b0 || bus.C_r_wb !== 1'b0 || bus.C_addr !== 8'h00 ||
        bus.C_data_w !== 64'h0 || bus.resp_rdata !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_state: ready=%b resp=%b done=%b cin=%b rwb=%b caddr=%h cdw=%h rdata=%h, want ready=1 rest 0",
               bus.req_ready, bus.resp_valid, bus.flush_done, bus.C_in_valid, bus.C_r_wb,
               bus.C_addr, bus.C_data_w, bus.resp_rdata);
    end
  endtask

  task automatic test_read_fill_and_hit();
    mem[8'h10] = 64'h1122334455667788; arch[8'h10] = mem[8'h10];
    d = $urandom_range(1, 4);
    model_req(1'b0, 8'h10, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h10, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (fc !== 1 || nf !== 1 || fa !== 8'h10 || nwb !== 0) begin
      tests_failed++;
      $display("FAIL fill_request: cin_cyc=%0d fills=%0d addr=%h wbs=%0d, want 1 1 10 0", fc, nf, fa, nwb);
    end
    tests_run++;
    if (rc !== 2 + d || rd !== 64'h1122334455667788 || !ok) begin
      tests_failed++;
      $display("FAIL fill_response: cyc=%0d data=%h ok=%b, want cyc=%0d data=1122334455667788 ok=1", rc, rd, ok, 2 + d);
    end
    model_req(1'b0, 8'h10, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h10, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (rc !== 1 || rd !== 64'h1122334455667788 || nf !== 0 || nwb !== 0 || !ok) begin
      tests_failed++;
      $display("FAIL read_hit: cyc=%0d data=%h bridge=%0d ok=%b, want cyc=1 data=1122334455667788 bridge=0", rc, rd, nf + nwb, ok);
    end
  endtask

  task automatic test_write_hit_then_writeback();
    d = $urandom_range(1, 4);
    model_req(1'b1, 8'h10, 64'hAAAA, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 1, 8'h10, 64'hAAAA, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (rc !== 1 || rd !== 64'hAAAA || nf + nwb !== 0 || !ok) begin
      tests_failed++;
      $display("FAIL write_hit: cyc=%0d data=%h bridge=%0d, want cyc=1 data=aaaa bridge=0", rc, rd, nf + nwb);
    end
    model_req(1'b0, 8'h20, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h20, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (nwb !== 1 || wa !== 8'h10 || wdd !== 64'hAAAA) begin
      tests_failed++;
      $display("FAIL dirty_writeback: wbs=%0d addr=%h data=%h, want 1 10 aaaa", nwb, wa, wdd);
    end
    tests_run++;
    if (nf !== 1 || fa !== 8'h20 || rc !== 3 + 2 * d || rd !== erd || !ok) begin
      tests_failed++;
      $display("FAIL miss_after_wb: fills=%0d addr=%h cyc=%0d data=%h ok=%b, want 1 20 %0d %h", nf, fa, rc, rd, ok, 3 + 2 * d, erd);
    end
  endtask

  task automatic test_write_miss_and_flush();
    d = $urandom_range(1, 4);
    model_req(1'b1, 8'h30, 64'h0BAD_CAFE_1234_5678, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 1, 8'h30, 64'h0BAD_CAFE_1234_5678, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (rc !== 1 || rd !== 64'h0BAD_CAFE_1234_5678 || nf + nwb !== 0 || !ok) begin
      tests_failed++;
      $display("FAIL clean_write_miss: cyc=%0d data=%h bridge=%0d, want cyc=1 data=0badcafe12345678 bridge=0", rc, rd, nf + nwb);
    end
    model_flush(ewb, ewa, ewd);
    run_op(1, 0, 0, 8'h00, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (nwb !== 1 || wa !== 8'h30 || wdd !== 64'h0BAD_CAFE_1234_5678 || nf !== 0 || dc !== 2 + d || !ok) begin
      tests_failed++;
      $display("FAIL dirty_flush: wbs=%0d addr=%h data=%h fills=%0d done=%0d, want 1 30 0badcafe12345678 0 %0d", nwb, wa, wdd, nf, dc, 2 + d);
    end
    model_req(1'b0, 8'h30, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h30, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (nf !== 1 || nwb !== 0 || rd !== 64'h0BAD_CAFE_1234_5678 || !ok) begin
      tests_failed++;
      $display("FAIL read_after_flush: fills=%0d wbs=%0d data=%h, want 1 0 0badcafe12345678", nf, nwb, rd);
    end
  endtask

  task automatic test_flush_priority();
    d = $urandom_range(1, 4);
    model_req(1'b0, 8'h40, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h40, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    model_flush(ewb, ewa, ewd);
    model_req(1'b0, 8'h40, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(1, 1, 0, 8'h40, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (dc !== 1 || nf !== 1 || rc !== 4 + d || rd !== erd || !ok) begin
      tests_failed++;
      $display("FAIL flush_priority: done=%0d fills=%0d resp=%0d data=%h ok=%b, want 1 1 %0d %h", dc, nf, rc, rd, ok, 4 + d, erd);
    end
  endtask

  task automatic test_reset_in_fill_wait();
    int stray;
    model_flush(ewb, ewa, ewd);
    run_op(1, 0, 0, 8'h00, 64'h0, 2, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 8'h55;
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests_run++;
    if (bus.C_in_valid !== 1'b1 || bus.C_r_wb !== 1'b1 || bus.C_addr !== 8'h55) begin
      tests_failed++;
      $display("FAIL pre_reset_fill: cin=%b rwb=%b addr=%h, want 1 1 55", bus.C_in_valid, bus.C_r_wb, bus.C_addr);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.C_in_valid !== 1'b0 ||
        bus.C_r_wb !== 1'b0 || bus.C_addr !== 8'h00 || bus.C_data_w !== 64'h0 ||
        bus.resp_rdata !== 64'h0 || bus.flush_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_fill_wait: ready=%b resp=%b cin=%b rwb=%b addr=%h rdata=%h, want ready=1 rest 0",
               bus.req_ready, bus.resp_valid, bus.C_in_valid, bus.C_r_wb, bus.C_addr, bus.resp_rdata);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.C_out_valid = 1'b1; bus.C_data_r = 64'hDEAD_DEAD_DEAD_DEAD;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.C_out_valid = 1'b0;
      if (bus.resp_valid !== 1'b0 || bus.C_in_valid !== 1'b0) stray++;
    end
    tests_run++;
    if (stray !== 0) begin
      tests_failed++;
      $display("FAIL late_bridge_ignored: stray_cycles=%0d, want 0", stray);
    end
    model_req(1'b0, 8'h55, 64'h0, ewb, ewa, ewd, efill, erd);
    run_op(0, 1, 0, 8'h55, 64'h0, 1, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
    tests_run++;
    if (nf !== 1 || rd !== erd || !ok) begin
      tests_failed++;
      $display("FAIL read_after_reset: fills=%0d data=%h ok=%b, want 1 %h", nf, rd, ok, erd);
    end
  endtask

  task automatic test_random();
    int r;
    bit wr, fl;
    logic [7:0]  a;
    logic [63:0] wd;
    int obs;
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      fl = (r == 9);
      wr = (r < 4);
      a  = 8'h80 + 8'($urandom_range(0, 4));
      wd = {$urandom, $urandom};
      d  = $urandom_range(1, 5);
      if (fl) begin
        model_flush(ewb, ewa, ewd);
        efill = 0;
        run_op(1, 0, 0, 8'h00, 64'h0, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
        obs = dc;
      end else begin
        model_req(wr, a, wd, ewb, ewa, ewd, efill, erd);
        run_op(0, 1, wr, a, wd, d, rc, rd, dc, fc, nwb, nf, wa, wdd, fa, ok);
        obs = rc;
      end
      tests_run++;
      if (nwb !== ewb || nf !== efill || obs !== 1 + (ewb + efill) * (d + 1) || !ok) begin
        tests_failed++;
        $display("FAIL rand_traffic[%0d]: wbs=%0d fills=%0d cyc=%0d ok=%b, want %0d %0d %0d", i, nwb, nf, obs, ok,
                 ewb, efill, 1 + (ewb + efill) * (d + 1));
      end
      if (ewb == 1) begin
        tests_run++;
        if (wa !== ewa || wdd !== ewd) begin
          tests_failed++;
          $display("FAIL rand_writeback[%0d]: addr=%h data=%h, want %h %h", i, wa, wdd, ewa, ewd);
        end
      end
      if (!fl) begin
        tests_run++;
        if (rd !== erd) begin
          tests_failed++;
          $display("FAIL rand_rdata[%0d]: addr=%h data=%h, want %h", i, a, rd, erd);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.flush_valid = 1'b0; bus.C_out_valid = 1'b0; bus.C_data_r = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_read_fill_and_hit();
    test_write_hit_then_writeback();
    test_write_miss_and_flush();
    test_flush_priority();
    test_reset_in_fill_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
